prbs_multi_gen_chk: RTL

//  Parametrised PRBS7/15/23/31 pattern generator and self-synchronising checker for link/pad bring-up.

---
 rtl/prbs_multi_gen_chk_if.sv | 28 ++
 rtl/prbs_multi_gen_chk.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/prbs_multi_gen_chk_if.sv
// Bus bundle for the PRBS generator/checker.
// The master side (bench or register bank) drives mode, gen_en and the checker inputs.
// The slave side (the PRBS block) returns the generated word and the checker status.
interface prbs_multi_gen_chk_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic [1:0]       mode;
    logic             gen_en;
    logic [W-1:0]     gen_data;
    logic             gen_valid;
    logic             chk_valid;
    logic [W-1:0]     chk_data;
    logic             clr_cnt;
    logic             chk_locked;
    logic [CNT_W-1:0] err_count;
    logic             err_sticky;

    modport master (
        output mode, gen_en, chk_valid, chk_data, clr_cnt,
        input  gen_data, gen_valid, chk_locked, err_count, err_sticky
    );

    modport slave (
        input  mode, gen_en, chk_valid, chk_data, clr_cnt,
        output gen_data, gen_valid, chk_locked, err_count, err_sticky
    );
endinterface

// File: rtl/prbs_multi_gen_chk.sv
// PRBS7/15/23/31 word generator plus self-synchronising checker.
// The generator is a Fibonacci LFSR emitting W bits per enabled cycle, oldest bit in
// gen_data[W-1]. The checker predicts each received bit from the two tap positions of
// its own receive history, so it locks onto any phase of the selected sequence.
// Optional build macro PRBS_ERR_INJECT_EN adds the inj_err port, which inverts
// gen_data[W-1] of the word generated in that cycle without disturbing the LFSR.
// rst_n is asynchronous and active-high despite its name; it matches the reset net
// already used by the surrounding design.
module prbs_multi_gen_chk #(
    parameter int W        = 8,   // bits per word, 1..32
    parameter int CNT_W    = 16,  // saturating error counter width
    parameter int LOCK_CNT = 4,   // clean words to lock, 1..255
    parameter int LOSS_CNT = 4    // errored words to lose lock, 1..255
) (
    input  logic clk,
    input  logic rst_n,
`ifdef PRBS_ERR_INJECT_EN
    input  logic inj_err,
`endif
    prbs_multi_gen_chk_if.slave bus
);
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    localparam logic [30:0] SEED  = '1;
    localparam int          SUM_W = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [1:0]       mode_q;
    logic [30:0]      gen_lfsr_q, gen_lfsr_d;
    logic [W-1:0]     gen_data_q;
    logic             gen_valid_q;
    logic [30:0]      chk_hist_q, chk_hist_d;
    logic [5:0]       fill_q;
    chk_state_e       state_q;
    logic [7:0]       run_q;
    logic [CNT_W-1:0] err_q;
    logic             sticky_q;

    logic             mode_chg;
    logic [4:0]       ord_m1, tap_m1;
    logic [W-1:0]     gen_word, inj_mask, mism;
    logic [5:0]       mism_cnt;
    logic             filled, count_en, err_sat;
    logic [8:0]       run_inc;
    logic [SUM_W-1:0] err_sum;

    // Tap positions (order N and second tap a, both minus one) of the active polynomial.
    always_comb begin
        // NOTE: give every combinational output a default first so no path can infer a latch.
        ord_m1 = 5'd6;
        tap_m1 = 5'd5;
        case (mode_q)
            2'd1:    begin ord_m1 = 5'd14; tap_m1 = 5'd13; end
            2'd2:    begin ord_m1 = 5'd22; tap_m1 = 5'd17; end
            2'd3:    begin ord_m1 = 5'd30; tap_m1 = 5'd27; end
            default: begin ord_m1 = 5'd6;  tap_m1 = 5'd5;  end
        endcase
    end

    // Generator: unroll W LFSR steps; bit [0] of the shift state is the newest bit.
    always_comb begin
        gen_lfsr_d = gen_lfsr_q;
        gen_word   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            // NOTE: blocking assignments here chain the unrolled steps; registers use <= only.
            gen_word[i] = gen_lfsr_d[tap_m1] ^ gen_lfsr_d[ord_m1];
            gen_lfsr_d  = {gen_lfsr_d[29:0], gen_word[i]};
        end
    end

    // Optional single-bit corruption of the oldest bit of the outgoing word.
    always_comb begin
        inj_mask = '0;
`ifdef PRBS_ERR_INJECT_EN
        inj_mask[W-1] = inj_err;
`endif
    end

    // Checker: predict each bit from the history, earlier bits of this word included.
    always_comb begin
        chk_hist_d = chk_hist_q;
        mism       = '0;
        mism_cnt   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            mism[i]    = bus.chk_data[i] ^ chk_hist_d[tap_m1] ^ chk_hist_d[ord_m1];
            chk_hist_d = {chk_hist_d[29:0], bus.chk_data[i]};
        end
        for (int i = 0; i < W; i++) begin
            mism_cnt = mism_cnt + 6'(mism[i]);
        end
    end

    // Compares are trusted only after a whole order's worth of bits has been seen.
    assign mode_chg = (bus.mode != mode_q);
    assign filled   = (fill_q > {1'b0, ord_m1});
    assign run_inc  = {1'b0, run_q} + 9'd1;
    assign count_en = bus.chk_valid && !mode_chg && (state_q == LOCKED);
    assign err_sum  = SUM_W'(err_q) + SUM_W'(mism_cnt);
    assign err_sat  = (err_sum > CNT_MAX);

    // Mode tracking, generator, checker FSM and error counter; all outputs registered.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: the history registers are reset too, because fill and lock depend on a known start.
            mode_q      <= 2'd0;
            gen_lfsr_q  <= SEED;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            chk_hist_q  <= '0;
            fill_q      <= '0;
            state_q     <= HUNT;
            run_q       <= '0;
            err_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            mode_q      <= bus.mode;
            gen_valid_q <= 1'b0;
            if (mode_chg) begin
                // Reload edge: gen_data holds, no word is generated or checked.
                gen_lfsr_q <= SEED;
                chk_hist_q <= '0;
                fill_q     <= '0;
                state_q    <= HUNT;
                run_q      <= '0;
            end else begin
                if (bus.gen_en) begin
                    gen_lfsr_q  <= gen_lfsr_d;
                    gen_data_q  <= gen_word ^ inj_mask;
                    gen_valid_q <= 1'b1;
                end
                if (bus.chk_valid) begin
                    chk_hist_q <= chk_hist_d;
                    if (!filled) begin
                        fill_q <= fill_q + 6'(W);
                    end
                    case (state_q)
                        HUNT: begin
                            if (filled) begin
                                if (mism_cnt != 6'd0) begin
                                    run_q <= '0;
                                end else if (run_inc >= 9'(LOCK_CNT)) begin
                                    state_q <= LOCKED;
                                    run_q   <= '0;
                                end else begin
                                    run_q <= run_inc[7:0];
                                end
                            end
                        end
                        LOCKED: begin
                            if (mism_cnt == 6'd0) begin
                                run_q <= '0;
                            end else if (run_inc >= 9'(LOSS_CNT)) begin
                                state_q <= HUNT;
                                run_q   <= '0;
                            end else begin
                                run_q <= run_inc[7:0];
                            end
                        end
                        default: state_q <= HUNT;
                    endcase
                end
            end
            // A clear in the same cycle as a counted word wins.
            if (bus.clr_cnt) begin
                err_q    <= '0;
                sticky_q <= 1'b0;
            end else if (count_en) begin
                err_q <= err_sat ? CNT_MAX[CNT_W-1:0] : err_sum[CNT_W-1:0];
                if (mism_cnt != 6'd0) begin
                    sticky_q <= 1'b1;
                end
            end
        end
    end

    assign bus.gen_data   = gen_data_q;
    assign bus.gen_valid  = gen_valid_q;
    assign bus.chk_locked = (state_q == LOCKED);
    assign bus.err_count  = err_q;
    assign bus.err_sticky = sticky_q;
endmodule
